// File: rtl/cpm_fifo_arb_ctrl_if.sv
// Handshake bundle between the CPM FIFO arbiter/sequencer, its producers, the FIFO and the consumer.
// master = the controller side, slave = the surrounding producers/FIFO/consumer.
interface cpm_fifo_arb_ctrl_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_push;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic                          fifo_Reset;
   logic                          fifo_pop;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic [ADDR_WIDTH:0]           fifo_count;
   logic                          cons_ready;

   modport master (
      input  req_valid, req_data, fifo_full, fifo_empty, fifo_count, cons_ready,
      output req_ready, fifo_push, fifo_data_in, fifo_Reset, fifo_pop
   );

   modport slave (
      output req_valid, req_data, fifo_full, fifo_empty, fifo_count, cons_ready,
      input  req_ready, fifo_push, fifo_data_in, fifo_Reset, fifo_pop
   );
endinterface

// File: rtl/cpm_fifo_arb_ctrl.sv
// Round-robin write arbiter and burst read sequencer for one shared zero-latency CPM FIFO.
// Optional feature macro CPM_ARB_PERF_EN adds a saturating stall_cnt output.
module cpm_fifo_arb_ctrl #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned BURST_LEN  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       flush,
   cpm_fifo_arb_ctrl_if.master        bus,
   output logic                       burst_start,
   output logic                       burst_done,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef CPM_ARB_PERF_EN
   ,
   output logic [15:0]                stall_cnt
`endif
);

   localparam int unsigned GntW = $clog2(NUM_REQ);
   localparam int unsigned CntW = ADDR_WIDTH + 1;
   localparam logic [CntW-1:0] BurstLenC = CntW'(BURST_LEN);

   typedef enum logic [2:0] {StIdle, StStart, StBurst, StDone, StClear} state_e;

   state_e          state_q;
   logic [GntW-1:0] rr_ptr_q;
   logic [GntW-1:0] rr_next;
   logic            flush_pend_q;
   logic [CntW-1:0] pop_cnt_q;
   logic [CntW-1:0] blen_q;
   logic [CntW-1:0] blen_d;
   logic            start_cond;

   logic [GntW-1:0] grant;
   logic [GntW-1:0] cand;
   logic            any_valid;
   logic            push_ok;

   // Search upward from rr_ptr, wrapping, for the first valid requester.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = GntW'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!any_valid && bus.req_valid[cand]) begin
            any_valid = 1'b1;
            grant     = cand;
         end
      end
   end

   assign push_ok = any_valid && !bus.fifo_full && (state_q != StClear);

   always_comb begin
      bus.req_ready = '0;
      if (push_ok) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   assign bus.fifo_push    = |(bus.req_valid & bus.req_ready);
   assign bus.fifo_data_in = bus.req_data[32'(grant) * DATA_WIDTH +: DATA_WIDTH];
   assign grant_id         = grant;
   assign rr_next          = (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;

   // Pops are not gated by clear: the pop in the same cycle as clear still completes.
   assign bus.fifo_pop   = (state_q == StBurst) && bus.cons_ready && !bus.fifo_empty;
   assign bus.fifo_Reset = (state_q == StClear);
   assign busy           = (state_q != StIdle);

   assign start_cond = (bus.fifo_count >= BurstLenC) || (flush_pend_q && !bus.fifo_empty);
   assign blen_d     = (bus.fifo_count < BurstLenC) ? bus.fifo_count : BurstLenC;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         flush_pend_q <= 1'b0;
         pop_cnt_q    <= '0;
         blen_q       <= '0;
         burst_start  <= 1'b0;
         burst_done   <= 1'b0;
      end else begin
         burst_start <= 1'b0;
         burst_done  <= 1'b0;

         if (bus.fifo_push) begin
            rr_ptr_q <= rr_next;
         end

         if (clear || state_q == StClear) begin
            flush_pend_q <= 1'b0;
         end else if (flush) begin
            flush_pend_q <= 1'b1;
         end else if (state_q == StIdle && bus.fifo_empty) begin
            flush_pend_q <= 1'b0;
         end

         if (clear) begin
            state_q   <= StClear;
            pop_cnt_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start_cond) begin
                     state_q     <= StStart;
                     blen_q      <= blen_d;
                     burst_start <= 1'b1;
                  end
               end
               StStart: state_q <= StBurst;
               StBurst: begin
                  if (bus.fifo_pop) begin
                     if (pop_cnt_q == blen_q - 1'b1) begin
                        state_q    <= StDone;
                        pop_cnt_q  <= '0;
                        burst_done <= 1'b1;
                     end else begin
                        pop_cnt_q <= pop_cnt_q + 1'b1;
                     end
                  end
               end
               StDone: state_q <= StIdle;
               StClear: begin
                  state_q   <= StIdle;
                  pop_cnt_q <= '0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

`ifdef CPM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state_q == StClear) begin
         stall_cnt <= '0;
      end else if (|bus.req_valid && bus.fifo_full && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
